// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and its stall/flush controller.
//
// Signals (direction seen from the controller):
//   id_rs, id_rt       in   rs/rt fields of the instruction in ID
//   ex_mem_read        in   load in EX (ID/EX M-group MemRead)
//   ex_rt              in   destination rt of the load in EX
//   mem_read/mem_write in   EX/MEM M-group access bits
//   branch_taken       in   branch/jump resolved taken
//   mem_ack            in   data memory completes the current access
//   pc_en ... mem_req  out  pipeline register enables/flushes, memory request
//   ctrl_err           out  sticky handshake-timeout error
//   state              out  controller state, for debug
//   stall_cycles,
//   flush_events       out  performance counters (only with PIPE_CTRL_PERF_EN)
//
// Modports: master = pipeline/datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       mem_read;
    logic       mem_write;
    logic       branch_taken;
    logic       mem_ack;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       mem_wb_flush;
    logic       mem_req;
    logic       ctrl_err;
    logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, mem_read, mem_write,
               branch_taken, mem_ack,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_flush, mem_req, ctrl_err, state
`ifdef PIPE_CTRL_PERF_EN
       ,input  stall_cycles, flush_events
`endif
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, mem_read, mem_write,
               branch_taken, mem_ack,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_flush, mem_req, ctrl_err, state
`ifdef PIPE_CTRL_PERF_EN
       ,output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Resolves load-use,
// taken branch/jump and multi-cycle data-memory accesses (req/ack handshake)
// and watches the handshake with a timeout that parks the controller in ERR.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-high
//   hz     pipeline_hazard_ctrl_if.slave (hazard inputs, enables/flushes,
//          mem_req, ctrl_err, state)
//
// Parameters:
//   MEM_TIMEOUT  wait cycles tolerated without mem_ack (1..255)
//   TO_CNT_W     width of the timeout counter
//
// Optional: define PIPE_CTRL_PERF_EN to add the stall_cycles / flush_events
// saturating performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; load-use and branch handling
// MEM_WAIT | data access outstanding, pipeline frozen, timeout counting
// ERR      | handshake timed out; pipeline held flushed until reset
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t              state_q, state_next;
    logic [TO_CNT_W-1:0] cnt_q, cnt_next;
    logic [TO_CNT_W:0]   cnt_inc;
    logic                err_q, err_next;
    logic                memop, luse, advance, br_flush;

    assign memop   = hz.mem_read | hz.mem_write;
    assign luse    = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                     ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
    assign cnt_inc = {1'b0, cnt_q} + {{TO_CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            err_q   <= err_next;
        end
    end

    always_comb begin
        state_next      = state_q;
        cnt_next        = cnt_q;
        err_next        = err_q;
        advance         = 1'b0;
        br_flush        = 1'b0;
        hz.pc_en        = 1'b0;
        hz.if_id_en     = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_en     = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_en    = 1'b0;
        hz.mem_wb_flush = 1'b0;
        hz.mem_req      = 1'b0;

        case (state_q)
            RUN: begin
                if (memop && !hz.mem_ack) begin
                    hz.mem_req      = 1'b1;
                    hz.mem_wb_flush = 1'b1;
                    state_next      = MEM_WAIT;
                    cnt_next        = TO_CNT_W'(1);
                end else begin
                    hz.mem_req = memop;
                    advance    = 1'b1;
                end
            end
            MEM_WAIT: begin
                hz.mem_req = 1'b1;
                // The ack is checked first so it beats a timeout in the same cycle.
                if (hz.mem_ack) begin
                    advance    = 1'b1;
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    hz.mem_wb_flush = 1'b1;
                    cnt_next        = cnt_inc[TO_CNT_W-1:0];
                    if (cnt_inc >= (TO_CNT_W+1)'(MEM_TIMEOUT)) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end
                end
            end
            ERR: begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_flush  = 1'b1;
                hz.mem_wb_flush = 1'b1;
                err_next        = 1'b1;
            end
            default: begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_flush  = 1'b1;
                hz.mem_wb_flush = 1'b1;
                state_next      = RUN;
                cnt_next        = '0;
            end
        endcase

        // Issue rules shared by RUN and the ack cycle of MEM_WAIT. A taken
        // branch kills the ID instruction, so a concurrent load-use is moot.
        if (advance) begin
            hz.ex_mem_en = 1'b1;
            if (hz.branch_taken) begin
                hz.pc_en       = 1'b1;
                hz.if_id_en    = 1'b1;
                hz.id_ex_en    = 1'b1;
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
                br_flush       = 1'b1;
            end else if (luse) begin
                hz.id_ex_en    = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else begin
                hz.pc_en    = 1'b1;
                hz.if_id_en = 1'b1;
                hz.id_ex_en = 1'b1;
            end
        end

        // Reset abandons any outstanding request in the same cycle.
        if (reset) begin
            state_next      = RUN;
            cnt_next        = '0;
            err_next        = 1'b0;
            br_flush        = 1'b0;
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_en     = 1'b0;
            hz.ex_mem_en    = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.mem_wb_flush = 1'b1;
            hz.mem_req      = 1'b0;
        end
    end

    assign hz.ctrl_err = err_q;
    assign hz.state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!hz.pc_en && (state_q != ERR) && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (br_flush && (flush_q != '1))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .TO_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    // Output vector: pc,if_id_en,if_id_fl,id_ex_en,id_ex_fl,ex_mem_en,mem_wb_fl,req,err,state[1:0]
    localparam logic [10:0] V_RST_RUN  = 11'b0_0_1_0_1_0_1_0_0_00;
    localparam logic [10:0] V_RST_WAIT = 11'b0_0_1_0_1_0_1_0_0_01;
    localparam logic [10:0] V_RST_ERR  = 11'b0_0_1_0_1_0_1_0_1_10;
    localparam logic [10:0] V_NORM     = 11'b1_1_0_1_0_1_0_0_0_00;
    localparam logic [10:0] V_ZW       = 11'b1_1_0_1_0_1_0_1_0_00;
    localparam logic [10:0] V_LUSE     = 11'b0_0_0_1_1_1_0_0_0_00;
    localparam logic [10:0] V_BR       = 11'b1_1_1_1_1_1_0_0_0_00;
    localparam logic [10:0] V_REQ      = 11'b0_0_0_0_0_0_1_1_0_00;
    localparam logic [10:0] V_WAIT     = 11'b0_0_0_0_0_0_1_1_0_01;
    localparam logic [10:0] V_ACK      = 11'b1_1_0_1_0_1_0_1_0_01;
    localparam logic [10:0] V_ACK_BR   = 11'b1_1_1_1_1_1_0_1_0_01;
    localparam logic [10:0] V_ERR      = 11'b0_0_1_0_1_0_1_0_1_10;

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic exmr, input logic [4:0] exrt, input logic mr,
                         input logic mw, input logic br, input logic ack);
        reset           = rst;
        hz.id_rs        = rs;
        hz.id_rt        = rt;
        hz.ex_mem_read  = exmr;
        hz.ex_rt        = exrt;
        hz.mem_read     = mr;
        hz.mem_write    = mw;
        hz.branch_taken = br;
        hz.mem_ack      = ack;
    endtask

    // Inputs are already applied just after a rising edge; the expected
    // vector is queued, the outputs are sampled mid-cycle and scored.
    task automatic step(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        logic [10:0] e;
        exp_q.push_back(exp);
        #4;
        got = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
               hz.ex_mem_en, hz.mem_wb_flush, hz.mem_req, hz.ctrl_err, hz.state};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step("reset_run", V_RST_RUN);

        drive(0, 1, 2, 0, 0, 0, 0, 0, 0);
        step("normal", V_NORM);

        // Load-use on rs, then the bubble has moved into EX.
        drive(0, 5, 2, 1, 5, 0, 0, 0, 0);
        step("luse_rs", V_LUSE);
        drive(0, 5, 2, 0, 0, 0, 0, 0, 0);
        step("luse_after", V_NORM);
        drive(0, 3, 7, 1, 7, 0, 0, 0, 0);
        step("luse_rt", V_LUSE);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("luse_r0", V_NORM);
        drive(0, 4, 9, 1, 6, 0, 0, 0, 0);
        step("luse_nomatch", V_NORM);

        // Branch with a concurrent load-use.
        drive(0, 5, 2, 1, 5, 0, 0, 1, 0);
        step("branch_luse", V_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("branch_after", V_NORM);

        // Zero-wait access and stray ack.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("zero_wait", V_ZW);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("stray_ack", V_NORM);

        // Multi-cycle load: ack low 3 cycles, then high.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("mc_req", V_REQ);
        step("mc_wait1", V_WAIT);
        step("mc_wait2", V_WAIT);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("mc_ack", V_ACK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mc_done", V_NORM);

        // Branch held during the wait, acted on in the ack cycle.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("br_req", V_REQ);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("br_wait", V_WAIT);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("br_ack", V_ACK_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("br_done", V_NORM);

        // Ack arrives on the 15th wait cycle: ack beats the timeout.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("ack15_req", V_REQ);
        for (int i = 2; i <= 14; i++) step("ack15_wait", V_WAIT);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("ack15_ack", V_ACK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("ack15_done", V_NORM);

        // Timeout: 15 wait cycles without ack, then sticky ERR.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("to_req", V_REQ);
        for (int i = 2; i <= 15; i++) step("to_wait", V_WAIT);
        step("to_err", V_ERR);
        drive(0, 5, 0, 1, 5, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step("err_hold", V_ERR);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("err_reset", V_RST_ERR);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("err_cleared", V_NORM);

        // Reset during wait cycle 2 drops the request immediately.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("rw_req", V_REQ);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step("rw_reset", V_RST_WAIT);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rw_after", V_NORM);

        // A pending access outranks load-use.
        drive(0, 5, 0, 1, 5, 1, 0, 0, 0);
        step("prio_req", V_REQ);
        drive(0, 5, 0, 1, 5, 1, 0, 0, 1);
        step("prio_ack_luse", 11'b0_0_0_1_1_1_0_1_0_01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
